fpser_ctrl: RTL and testbench
=============================

Name: fpser_ctrl

Overview:
- Parametrised serial command/response controller for floating-point units under test on the board.
- Receives a header byte plus 1 or 2 little-endian operands from the receive buffer, and drives the FP unit with a run/stall handshake.
- Captures the result and flags, then returns result bytes, a flag byte and an optional checksum through the transmit buffer.
- Generalises the single-operand test controller with operand count, widths, an opcode field and a stall watchdog.

Parameters:
- NUM_OPS, 2, operand count; legal values are 1 or 2.
- OPND_BYTES, 4, bytes per operand; legal range 1..8.
- RES_BYTES, 4, bytes per result; legal range 1..8.
- FLAG_BITS, 5, width of the unit's flag output; legal range 1..7.
- OP_BITS, 3, opcode field width; legal range 0..6.
- TIMEOUT, 0, stall watchdog limit in cycles; 0 disables the watchdog.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rcv_rdy  in  1  receive buffer holds a byte
- rcv_data  in  8  received byte
- rcv_read  out  1  pop the received byte
- xmt_rdy  in  1  transmit buffer accepts a byte
- xmt_wrt  out  1  push xmt_data
- xmt_data  out  8  byte to send
- run  out  1  FP unit operation request
- stall  in  1  FP unit busy
- rnd  out  2  rounding mode
- op  out  max(OP_BITS,1)  operation select
- x  out  8*OPND_BYTES  operand 1
- y  out  8*OPND_BYTES  operand 2; constant 0 when NUM_OPS=1
- z  in  8*RES_BYTES  unit result
- flags  in  FLAG_BITS  unit exception flags

Behaviour:
- Reset (asynchronous, any state): state=HDR, byte counter=0, rnd/op/x/y/z-capture/flag-capture=0. run, rcv_read and xmt_wrt read 0 while rst_n=0. Any frame in progress is discarded; the frame restarts at HDR after release.
- rcv_read = rcv_rdy while in HDR or OPND; 0 otherwise. A byte is consumed in exactly the cycle rcv_rdy&rcv_read.
- HDR: on consume, latch rnd=rcv_data[1:0] and op=rcv_data[OP_BITS+1:2]; unused header bits are ignored. Go to OPND with counter=0.
- OPND:
  - Byte k (0..NUM_OPS*OPND_BYTES-1) goes to x when k<OPND_BYTES, otherwise to y.
  - Byte lane is k mod OPND_BYTES; lowest byte is first.
  - On the last byte, go to EXEC.
  - Each byte lane updates only when its byte is consumed; all other bits hold.
- EXEC:
  - run=1 for every cycle in EXEC; rnd/op/x/y stay stable.
  - In the first EXEC cycle with stall=0, capture z and flags, clear the counter and go to XMT.
  - A zero-latency unit therefore sees run for exactly one cycle, and the response is ready 1 cycle after the last operand byte.
- Watchdog (TIMEOUT>0):
  - Counts consecutive EXEC cycles with stall=1.
  - When the count reaches TIMEOUT, capture z=0 and the flag byte as error code 8'hFF, and go to XMT. run drops to 0 next cycle.
  - The count clears on leaving EXEC.
- XMT:
  - xmt_wrt = xmt_rdy. The counter advances on each write.
  - Byte order: z byte 0..RES_BYTES-1, then the flag byte {0, flags}, or 8'hFF after a timeout.
  - After the last byte is written, go to HDR.
  - xmt_data is a combinational mux on the counter and stays valid while waiting on xmt_rdy.
- Boundaries:
  - Only one frame is in flight. Received bytes stay in the receive buffer (not read) during EXEC and XMT.
  - Back-to-back frames need no idle cycle: HDR can consume in the cycle after the final XMT write.
  - Unreachable states return to HDR with all strobes at 0.

Optional Feature:
- Macro: FPSER_CHKSUM_EN.
- Defined: after the flag byte, one extra byte is sent. Its value is the XOR of the header, all operand bytes, all result bytes and the flag byte. It is accumulated in an 8-bit register cleared in HDR before the header is consumed.
- Undefined: the frame ends with the flag byte and no checksum register is synthesised.

Decomposition:
- Package fpser_pkg holds:
  - the state encoding (HDR, OPND, EXEC, XMT, CHK);
  - FPSER_ERR_FLAGS = 8'hFF;
  - a function computing the counter width from NUM_OPS, OPND_BYTES and RES_BYTES.
- Sub-module fpser_wdog holds the stall watchdog counter: inputs clk, rst_n, clr, tick; output expired. It is instantiated only when TIMEOUT>0.

Test Plan:
- Single-op, default widths: send 02 00 00 80 3F, stub returns z=3F800000 flags=0 with zero latency -> rnd=2, x=3F800000, run high for 1 cycle; transmitted 00 00 80 3F 00.
- Two-op frame with op=5 (header 0x15): x bytes 01 02 03 04, y bytes AA BB CC DD -> x=04030201, y=DDCCBBAA, op=5, rnd=1 stable throughout EXEC.
- Stall for 7 cycles, then z=7F800000 flags=5'h04 -> run high for 8 cycles, response 00 00 80 7F 04; xmt_rdy toggled 1-0-1 must give no duplicated or skipped bytes.
- TIMEOUT=16, stall stuck at 1 -> run drops after exactly 16 cycles; response 00 00 00 00 FF; the next frame is processed normally.
- rst_n pulsed low while in OPND after 3 bytes -> outputs clear immediately; a fresh frame after release is decoded correctly.
- FPSER_CHKSUM_EN defined: frame 00 01 00 00 00, z=00000001 flags=0 -> trailing checksum byte 00 (XOR of all 10 frame bytes).

Source files
------------

// File: rtl/fpser_pkg.sv
// rtl/fpser_pkg.sv - shared state encoding, error code and counter sizing for the FP serial controller
package fpser_pkg;

    typedef enum logic [2:0] {
        S_HDR  = 3'd0,
        S_OPND = 3'd1,
        S_EXEC = 3'd2,
        S_XMT  = 3'd3,
        S_CHK  = 3'd4
    } fpser_state_t;

    localparam logic [7:0] FPSER_ERR_FLAGS = 8'hFF;

    // The byte counter indexes operand bytes in OPND and result+flag bytes in XMT.
    function automatic int fpser_cnt_w(input int nops, input int opnd_bytes, input int res_bytes);
        int m;
        int w;
        m = nops * opnd_bytes - 1;
        if (res_bytes > m) m = res_bytes;
        w = 1;
        while ((1 << w) <= m) w++;
        return w;
    endfunction

endpackage

// File: rtl/fpser_ctrl_wdog.sv
// rtl/fpser_ctrl_wdog.sv - stall watchdog: counts consecutive ticks, expires on the LIMIT-th one
module fpser_wdog #(
    parameter int LIMIT = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_tick,
    output logic o_expired
);

    localparam int WW = $clog2(LIMIT + 1);

    logic [WW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || !i_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = i_tick && (r_cnt == WW'(LIMIT - 1));

endmodule

// File: rtl/fpser_ctrl.sv
// rtl/fpser_ctrl.sv - serial command/response controller for an FP unit under test
// Optional trailing checksum byte: FPSER_CHKSUM_EN.
module fpser_ctrl
    import fpser_pkg::*;
#(
    parameter int NUM_OPS    = 2,
    parameter int OPND_BYTES = 4,
    parameter int RES_BYTES  = 4,
    parameter int FLAG_BITS  = 5,
    parameter int OP_BITS    = 3,
    parameter int TIMEOUT    = 0
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_rcv_rdy,
    input  logic [7:0]                      i_rcv_data,
    output logic                            o_rcv_read,
    input  logic                            i_xmt_rdy,
    output logic                            o_xmt_wrt,
    output logic [7:0]                      o_xmt_data,
    output logic                            o_run,
    input  logic                            i_stall,
    output logic [1:0]                      o_rnd,
    output logic [((OP_BITS > 0) ? OP_BITS : 1)-1:0] o_op,
    output logic [8*OPND_BYTES-1:0]         o_x,
    output logic [8*OPND_BYTES-1:0]         o_y,
    input  logic [8*RES_BYTES-1:0]          i_z,
    input  logic [FLAG_BITS-1:0]            i_flags
);

    localparam int OPW = (OP_BITS > 0) ? OP_BITS : 1;
    localparam int CW  = fpser_cnt_w(NUM_OPS, OPND_BYTES, RES_BYTES);
    localparam int OB  = 8 * OPND_BYTES;
    localparam int RB  = 8 * RES_BYTES;
    localparam logic [CW-1:0] LAST_OPND = CW'(NUM_OPS * OPND_BYTES - 1);
    localparam logic [CW-1:0] OPND_N    = CW'(OPND_BYTES);
    localparam logic [CW-1:0] RES_N     = CW'(RES_BYTES);

    fpser_state_t   r_state;
    fpser_state_t   w_next;
    logic [CW-1:0]  r_cnt;
    logic [1:0]     r_rnd;
    logic [OPW-1:0] r_op;
    logic [OB-1:0]  r_x;
    logic [OB-1:0]  r_y;
    logic [RB-1:0]  r_z;
    logic [7:0]     r_flg;

    logic           w_consume;
    logic           w_expired;
    logic [OPW-1:0] w_hdr_op;
    logic [7:0]     w_zbyte;
    logic [7:0]     w_xdata;
    logic [CW-1:0]  w_lane;
    logic           w_to_y;

`ifdef FPSER_CHKSUM_EN
    logic [7:0]     r_chk;
    logic [7:0]     w_zxor;
`endif

    generate
        if (TIMEOUT > 0) begin : g_wdog
            logic w_wd_clr;
            logic w_wd_tick;
            assign w_wd_clr  = (r_state != S_EXEC);
            assign w_wd_tick = (r_state == S_EXEC) && i_stall;
            fpser_wdog #(
                .LIMIT(TIMEOUT)
            ) u_wdog (
                .i_clk    (i_clk),
                .i_rst_n  (i_rst_n),
                .i_clr    (w_wd_clr),
                .i_tick   (w_wd_tick),
                .o_expired(w_expired)
            );
        end else begin : g_no_wdog
            assign w_expired = 1'b0;
        end
    endgenerate

    always_comb begin
        w_hdr_op = '0;
        for (int i = 0; i < OP_BITS; i++) w_hdr_op[i] = i_rcv_data[i+2];
    end

    always_comb begin
        w_zbyte = 8'h00;
        for (int b = 0; b < RES_BYTES; b++) begin
            if (r_cnt == CW'(b)) w_zbyte = r_z[8*b +: 8];
        end
    end

    // Second operand bytes reuse the same lane numbering as the first.
    assign w_to_y = (r_cnt >= OPND_N);
    assign w_lane = w_to_y ? (r_cnt - OPND_N) : r_cnt;

    always_comb begin
        w_next     = r_state;
        o_rcv_read = 1'b0;
        o_xmt_wrt  = 1'b0;
        o_run      = 1'b0;
        w_consume  = 1'b0;
        w_xdata    = 8'h00;
        case (r_state)
            S_HDR: begin
                o_rcv_read = i_rcv_rdy & i_rst_n;
                w_consume  = o_rcv_read;
                if (w_consume) w_next = S_OPND;
            end
            S_OPND: begin
                o_rcv_read = i_rcv_rdy & i_rst_n;
                w_consume  = o_rcv_read;
                if (w_consume && (r_cnt == LAST_OPND)) w_next = S_EXEC;
            end
            S_EXEC: begin
                o_run = 1'b1;
                if (!i_stall || w_expired) w_next = S_XMT;
            end
            S_XMT: begin
                o_xmt_wrt = i_xmt_rdy;
                w_xdata   = (r_cnt < RES_N) ? w_zbyte : r_flg;
                if (o_xmt_wrt && (r_cnt == RES_N)) begin
`ifdef FPSER_CHKSUM_EN
                    w_next = S_CHK;
`else
                    w_next = S_HDR;
`endif
                end
            end
`ifdef FPSER_CHKSUM_EN
            S_CHK: begin
                o_xmt_wrt = i_xmt_rdy;
                w_xdata   = r_chk;
                if (o_xmt_wrt) w_next = S_HDR;
            end
`endif
            default: w_next = S_HDR;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_HDR;
            r_cnt   <= '0;
            r_rnd   <= '0;
            r_op    <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_flg   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_HDR: begin
                    if (w_consume) begin
                        r_rnd <= i_rcv_data[1:0];
                        r_op  <= w_hdr_op;
                        r_cnt <= '0;
                    end
                end
                S_OPND: begin
                    if (w_consume) begin
                        r_cnt <= r_cnt + 1'b1;
                        for (int b = 0; b < OPND_BYTES; b++) begin
                            if (w_lane == CW'(b)) begin
                                if (w_to_y) r_y[8*b +: 8] <= i_rcv_data;
                                else        r_x[8*b +: 8] <= i_rcv_data;
                            end
                        end
                    end
                end
                S_EXEC: begin
                    if (w_expired) begin
                        r_z   <= '0;
                        r_flg <= FPSER_ERR_FLAGS;
                        r_cnt <= '0;
                    end else if (!i_stall) begin
                        r_z   <= i_z;
                        r_flg <= {{(8-FLAG_BITS){1'b0}}, i_flags};
                        r_cnt <= '0;
                    end
                end
                S_XMT: begin
                    if (o_xmt_wrt) r_cnt <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef FPSER_CHKSUM_EN
    always_comb begin
        w_zxor = {{(8-FLAG_BITS){1'b0}}, i_flags};
        for (int b = 0; b < RES_BYTES; b++) w_zxor = w_zxor ^ i_z[8*b +: 8];
    end

    // Header consume loads rather than XORs, which doubles as the per-frame clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_chk <= '0;
        end else begin
            case (r_state)
                S_HDR:  r_chk <= w_consume ? i_rcv_data : 8'h00;
                S_OPND: if (w_consume) r_chk <= r_chk ^ i_rcv_data;
                S_EXEC: begin
                    if (w_expired)     r_chk <= r_chk ^ FPSER_ERR_FLAGS;
                    else if (!i_stall) r_chk <= r_chk ^ w_zxor;
                end
                default: ;
            endcase
        end
    end
`endif

    assign o_xmt_data = w_xdata;
    assign o_rnd      = r_rnd;
    assign o_op       = r_op;
    assign o_x        = r_x;
    assign o_y        = (NUM_OPS == 2) ? r_y : '0;

endmodule

// File: tb/tb_fpser_ctrl.sv
// tb/tb_fpser_ctrl.sv - directed self-checking bench for fpser_ctrl (two operands, 16-cycle watchdog)
module tb_fpser_ctrl;

`ifdef FPSER_CHKSUM_EN
    localparam int NRESP = 6;
`else
    localparam int NRESP = 5;
`endif

    logic        clk;
    logic        rst_n;
    logic        rcv_rdy;
    logic [7:0]  rcv_data;
    logic        rcv_read;
    logic        xmt_rdy;
    logic        xmt_wrt;
    logic [7:0]  xmt_data;
    logic        run;
    logic        stall;
    logic [1:0]  rnd;
    logic [2:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
    logic [4:0]  flags;

    int checks = 0;
    int errors = 0;

    fpser_ctrl #(
        .NUM_OPS(2), .OPND_BYTES(4), .RES_BYTES(4),
        .FLAG_BITS(5), .OP_BITS(3), .TIMEOUT(16)
    ) u_dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_rcv_rdy(rcv_rdy), .i_rcv_data(rcv_data), .o_rcv_read(rcv_read),
        .i_xmt_rdy(xmt_rdy), .o_xmt_wrt(xmt_wrt), .o_xmt_data(xmt_data),
        .o_run(run), .i_stall(stall), .o_rnd(rnd), .o_op(op),
        .o_x(x), .o_y(y), .i_z(z), .i_flags(flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    task automatic put_byte(input logic [7:0] b, input string name);
        @(negedge clk);
        rcv_rdy  = 1'b1;
        rcv_data = b;
        #1;
        checks++;
        if (rcv_read !== 1'b1) begin
            errors++;
            $display("FAIL %s rcv_read got %b want 1 (byte %h)", name, rcv_read, b);
        end
    endtask

    task automatic do_frame(input logic [7:0] hdr, input logic [31:0] xv, input logic [31:0] yv,
                            input logic [31:0] zv, input logic [4:0] fv, input int n_stall,
                            input bit toggle, input int exp_runs, input bit is_to, input string name);
        logic [7:0] exp_b [0:5];
        logic [7:0] got   [0:5];
        logic [7:0] chk;
        int  runs;
        int  ngot;
        bit  bad_exec;
        bit  bad_hs;
        z     = zv;
        flags = fv;
        stall = 1'b0;
        put_byte(hdr, name);
        for (int i = 0; i < 4; i++) put_byte(xv[8*i +: 8], name);
        for (int i = 0; i < 4; i++) put_byte(yv[8*i +: 8], name);

        runs = 0;
        bad_exec = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            rcv_rdy  = 1'b1;
            rcv_data = 8'h5A;
            stall    = (c <= n_stall);
            #1;
            if (!run) break;
            runs++;
            if (x !== xv || y !== yv || op !== hdr[4:2] || rnd !== hdr[1:0] || rcv_read !== 1'b0)
                bad_exec = 1'b1;
        end
        stall   = 1'b0;
        rcv_rdy = 1'b0;
        checks++;
        if (runs != exp_runs) begin
            errors++;
            $display("FAIL %s run_cycles got %0d want %0d", name, runs, exp_runs);
        end
        checks++;
        if (bad_exec) begin
            errors++;
            $display("FAIL %s exec_stable got x=%h y=%h op=%0d rnd=%0d want x=%h y=%h op=%0d rnd=%0d",
                     name, x, y, op, rnd, xv, yv, hdr[4:2], hdr[1:0]);
        end

        for (int i = 0; i < 4; i++) exp_b[i] = is_to ? 8'h00 : zv[8*i +: 8];
        exp_b[4] = is_to ? 8'hFF : {3'b000, fv};
        chk = hdr;
        for (int i = 0; i < 4; i++) chk = chk ^ xv[8*i +: 8] ^ yv[8*i +: 8];
        for (int i = 0; i < 5; i++) chk = chk ^ exp_b[i];
        exp_b[5] = chk;

        ngot = 0;
        bad_hs = 1'b0;
        for (int c = 0; c < 64 && ngot < NRESP; c++) begin
            @(negedge clk);
            xmt_rdy = toggle ? (c % 2 == 0) : 1'b1;
            #1;
            if (xmt_wrt !== xmt_rdy) bad_hs = 1'b1;
            if (xmt_wrt === 1'b1) begin
                got[ngot] = xmt_data;
                ngot++;
            end
        end
        @(posedge clk);
        #1;
        xmt_rdy = 1'b0;
        checks++;
        if (ngot != NRESP || bad_hs) begin
            errors++;
            $display("FAIL %s resp_count got %0d want %0d handshake_err=%0d", name, ngot, NRESP, bad_hs);
        end
        for (int i = 0; i < NRESP; i++) begin
            checks++;
            if (i >= ngot || got[i] !== exp_b[i]) begin
                errors++;
                $display("FAIL %s resp_byte%0d got %h want %h", name, i, (i < ngot) ? got[i] : 8'hxx, exp_b[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rcv_rdy = 1'b1; rcv_data = 8'hFF; xmt_rdy = 1'b1;
        stall = 1'b0; z = '0; flags = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (run !== 1'b0 || rcv_read !== 1'b0 || xmt_wrt !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes got run=%b read=%b wrt=%b want 0 0 0", run, rcv_read, xmt_wrt);
        end
        checks++;
        if (x !== 32'h0 || y !== 32'h0 || rnd !== 2'd0 || op !== 3'd0) begin
            errors++;
            $display("FAIL reset_regs got x=%h y=%h rnd=%0d op=%0d want 0", x, y, rnd, op);
        end
        rcv_rdy = 1'b0; xmt_rdy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_frame(8'h02, 32'h3F800000, 32'h0, 32'h3F800000, 5'h00, 0, 1'b0, 1, 1'b0, "single");
    endtask

    task automatic test_two_op();
        do_frame(8'h15, 32'h04030201, 32'hDDCCBBAA, 32'h12345678, 5'h1F, 0, 1'b0, 1, 1'b0, "two_op");
    endtask

    task automatic test_stall_toggle();
        do_frame(8'h0B, 32'h00000080, 32'h7F000001, 32'h7F800000, 5'h04, 7, 1'b1, 8, 1'b0, "stall");
    endtask

    task automatic test_timeout();
        do_frame(8'h00, 32'h11111111, 32'h22222222, 32'hDEADBEEF, 5'h1F, 1000, 1'b0, 16, 1'b1, "timeout");
        do_frame(8'h06, 32'hCAFEF00D, 32'h0BADBEEF, 32'h40490FDB, 5'h01, 2, 1'b0, 3, 1'b0, "after_to");
    endtask

    task automatic test_reset_mid();
        put_byte(8'h1E, "rst_mid");
        put_byte(8'h11, "rst_mid");
        put_byte(8'h22, "rst_mid");
        put_byte(8'h33, "rst_mid");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (x !== 32'h0 || rnd !== 2'd0 || op !== 3'd0 || rcv_read !== 1'b0 || run !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_clear got x=%h rnd=%0d op=%0d read=%b run=%b want 0", x, rnd, op, rcv_read, run);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        rcv_rdy = 1'b0;
        do_frame(8'h1D, 32'h89ABCDEF, 32'h01234567, 32'h00000002, 5'h08, 0, 1'b0, 1, 1'b0, "post_rst");
    endtask

    task automatic test_back_to_back();
        do_frame(8'h00, 32'h00000001, 32'h0, 32'h00000001, 5'h00, 0, 1'b0, 1, 1'b0, "chk_zero");
        do_frame(8'h1F, 32'hFFFFFFFF, 32'h80000000, 32'hA5A55A5A, 5'h10, 1, 1'b1, 2, 1'b0, "b2b");
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_op();
        test_stall_toggle();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
